// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver state encoding, frame width and the detector/bit-period relation.
package uart_pkg;

    // The start-bit detector raises `process` SAMPLING_TICK cycles into the
    // start bit, so one full bit period is BIT_TICKS = 2*SAMPLING_TICK+1.
    localparam int DETECTOR_SAMPLING_TICK = 4;
    localparam int BIT_TICKS_DEFAULT      = 2 * DETECTOR_SAMPLING_TICK + 1;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-centre timer: counts 0..BIT_TICKS-1 and wraps.
// Ports: clk, rst (sync, active-high), clear (hold count at 0), tick (count at BIT_TICKS-1).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int BIT_TICKS = BIT_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_TICKS - 1);

    logic [CNT_W-1:0] tick_cnt;

    assign tick = (tick_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_shift.sv
// UART receive shifter: times bit centres after the detector's `process`, shifts in
// 8 data bits LSB-first, checks the stop bit and pulses vld_rx once per frame.
// Ports: clk, rst (sync, active-high), rxd, process in; d_rx, vld_rx, frm_err out
// (plus par_err when UART_RX_PARITY_EN is defined, which also adds a PARITY state).
module uart_rx_shift
    import uart_pkg::*;
#(
    parameter int BIT_TICKS = BIT_TICKS_DEFAULT
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 process,
    output logic [DATA_BITS-1:0] d_rx,
    output logic                 vld_rx,
`ifdef UART_RX_PARITY_EN
    output logic                 par_err,
`endif
    output logic                 frm_err
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 process_q;
    logic                 start;
    logic                 tick;
    logic                 clear;
    logic                 sample;
    logic                 frame_good;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;

    // Edge-qualified so a process still high just after vld_rx cannot retrigger.
    assign start  = process & ~process_q;
    assign sample = process & tick;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_bad;

    assign par_bad    = ^shift ^ par_bit ^ PARITY_ODD;
    assign frame_good = rxd & ~par_bad;
`else
    assign frame_good = rxd;
`endif

    uart_bit_timer #(
        .BIT_TICKS(BIT_TICKS)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                // Timer held at zero so the first data sample lands one bit after start.
                clear = 1'b1;
                if (start) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (!process) begin
                    state_next = IDLE;
                end else if (tick && bit_idx == LAST_IDX) begin
                    state_next = AFTER_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!process) begin
                    state_next = IDLE;
                end else if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (!process || tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            process_q <= 1'b0;
            bit_idx   <= '0;
            shift     <= '0;
            d_rx      <= '0;
            vld_rx    <= 1'b0;
            frm_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            process_q <= process;
            vld_rx    <= 1'b0;
            if (state == IDLE) begin
                bit_idx <= '0;
            end
            if (sample && state == DATA) begin
                shift   <= {rxd, shift[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (sample && state == PARITY) begin
                par_bit <= rxd;
            end
`endif
            if (sample && state == STOP) begin
                vld_rx  <= 1'b1;
                frm_err <= ~rxd;
`ifdef UART_RX_PARITY_EN
                par_err <= par_bad;
`endif
                // A bad frame leaves the previous good byte visible.
                if (frame_good) begin
                    d_rx <= shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_shift.sv
// Self-checking bench for uart_rx_shift: frame-level model plus per-cycle compare.
// Covers good/bad frames, back-to-back, mid-frame reset and abort, random traffic.
module tb_uart_rx_shift;
    import uart_pkg::*;

    localparam int BT   = 9;
    localparam int SAMP = (BT - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB   = 10;
    localparam int LAT  = 90;
`else
    localparam int NB   = 9;
    localparam int LAT  = 81;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       process = 1'b0;
    logic [7:0] d_rx;
    logic       vld_rx;
    logic       frm_err;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
    logic       exp_par = 1'b0;
    bit         pend_pbit;
`endif

    always #5 clk = ~clk;

    uart_rx_shift #(
        .BIT_TICKS(BT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .process(process),
        .d_rx   (d_rx),
        .vld_rx (vld_rx),
`ifdef UART_RX_PARITY_EN
        .par_err(par_err),
`endif
        .frm_err(frm_err)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         rst_cyc = -1;
    int         pend_cyc = 0;
    bit         pend_valid = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    bit         pend_stop = 1'b1;
    logic [7:0] exp_d = 8'h00;
    logic       exp_ferr = 1'b0;
    logic       exp_vld = 1'b0;
    bit         chk_en = 1'b0;
    bit         clr_pending = 1'b0;
    int         vld_cnt = 0;
    int         last_vld_cyc = 0;
    int         e0 = 0;
    int         cnt0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Frame-level expectation: a frame whose start was seen at E0 reports at E0+NB*BT.
    task automatic model_compare();
        exp_vld = 1'b0;
        if (cyc == rst_cyc) begin
            exp_d    = 8'h00;
            exp_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
            exp_par  = 1'b0;
`endif
        end
        if (pend_valid && cyc == pend_cyc) begin
            pend_valid = 1'b0;
            exp_vld    = 1'b1;
            exp_ferr   = !pend_stop;
`ifdef UART_RX_PARITY_EN
            exp_par = (^pend_byte) ^ pend_pbit;
            if (pend_stop && !exp_par) exp_d = pend_byte;
`else
            if (pend_stop) exp_d = pend_byte;
`endif
        end
        if (vld_rx === 1'b1) begin
            vld_cnt++;
            last_vld_cyc = cyc;
        end
        chk("vld_rx", 32'(vld_rx), 32'(exp_vld));
        chk("d_rx", 32'(d_rx), 32'(exp_d));
        chk("frm_err", 32'(frm_err), 32'(exp_ferr));
`ifdef UART_RX_PARITY_EN
        chk("par_err", 32'(par_err), 32'(exp_par));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (chk_en) model_compare();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            rxd = 1'b1;
        end
    endtask

    // Drives one frame on rxd and plays the detector on `process`.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit pbit,
                              input int gap, input int abort_at, input int rst_at);
        logic [10:0] bits;
        bit          aborted;
        aborted = 1'b0;
`ifdef UART_RX_PARITY_EN
        bits = {stop, pbit, b, 1'b0};
`else
        bits = {pbit, stop, b, 1'b0};
`endif
        for (int i = 0; i < (NB + 1) * BT + gap; i++) begin
            tick();
            rxd = (i < (NB + 1) * BT) ? bits[i / BT] : 1'b1;
            if (clr_pending) begin
                process     = 1'b0;
                clr_pending = 1'b0;
            end else if (process && vld_rx === 1'b1) begin
                clr_pending = 1'b1;
            end
            if (i == SAMP) begin
                process    = 1'b1;
                e0         = cyc + 1;
                pend_cyc   = e0 + NB * BT;
                pend_valid = 1'b1;
                pend_byte  = b;
                pend_stop  = stop;
`ifdef UART_RX_PARITY_EN
                pend_pbit  = pbit;
`endif
            end
            if (i == abort_at) begin
                process     = 1'b0;
                pend_valid  = 1'b0;
                clr_pending = 1'b0;
                aborted     = 1'b1;
            end
            if (rst_at >= 0 && i == rst_at) begin
                rst         = 1'b1;
                process     = 1'b0;
                pend_valid  = 1'b0;
                clr_pending = 1'b0;
                rst_cyc     = cyc + 1;
                aborted     = 1'b1;
            end
            if (rst_at >= 0 && i == rst_at + 1) rst = 1'b0;
        end
        if (!aborted) begin
            chk("frame_vld_seen", 32'(process), 32'd0);
            process     = 1'b0;
            clr_pending = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs;
        bit         rp;
        chk_en = 1'b1;
        rst    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_d_rx", 32'(d_rx), 32'h0);
        chk("reset_vld", 32'(vld_rx), 32'h0);
        chk("reset_ferr", 32'(frm_err), 32'h0);
        idle(10);

        send_frame(8'hA5, 1'b1, ^8'hA5, 9, -1, -1);
        chk("a5_d_rx", 32'(d_rx), 32'hA5);
        chk("a5_ferr", 32'(frm_err), 32'h0);
        chk("a5_latency", 32'(last_vld_cyc - e0), 32'(LAT));
        chk("a5_count", 32'(vld_cnt), 32'd1);

        send_frame(8'h00, 1'b1, 1'b0, 9, -1, -1);
        chk("b2b_00_d_rx", 32'(d_rx), 32'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 9, -1, -1);
        chk("b2b_ff_d_rx", 32'(d_rx), 32'hFF);
        chk("b2b_count", 32'(vld_cnt), 32'd3);

        send_frame(8'h3C, 1'b0, 1'b0, 9, -1, -1);
        chk("badstop_ferr", 32'(frm_err), 32'h1);
        chk("badstop_d_held", 32'(d_rx), 32'hFF);
        send_frame(8'h11, 1'b1, 1'b0, 9, -1, -1);
        chk("good_after_bad_ferr", 32'(frm_err), 32'h0);
        chk("good_after_bad_d", 32'(d_rx), 32'h11);

        cnt0 = vld_cnt;
        send_frame(8'h77, 1'b1, 1'b0, 9, -1, 5 * BT + 2);
        chk("rst_mid_d_rx", 32'(d_rx), 32'h00);
        chk("rst_mid_no_vld", 32'(vld_cnt), 32'(cnt0));
        send_frame(8'h5A, 1'b1, 1'b0, 9, -1, -1);
        chk("after_rst_d", 32'(d_rx), 32'h5A);

        cnt0 = vld_cnt;
        send_frame(8'h99, 1'b1, 1'b0, 9, 30, -1);
        chk("abort_d_held", 32'(d_rx), 32'h5A);
        chk("abort_no_vld", 32'(vld_cnt), 32'(cnt0));

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 9, -1, -1);
        chk("par_good_err", 32'(par_err), 32'h0);
        chk("par_good_d", 32'(d_rx), 32'h07);
        send_frame(8'h07, 1'b1, 1'b0, 9, -1, -1);
        chk("par_bad_err", 32'(par_err), 32'h1);
        chk("par_bad_d", 32'(d_rx), 32'h07);
`endif

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            rp = (^rb) ^ ($urandom_range(0, 4) == 0);
            send_frame(rb, rs, rp, $urandom_range(2, 25), -1, -1);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
